ps2_key_decoder: RTL

// - PS/2 keyboard receiver and scancode decoder. Produces the held-key levels that snake_ctlr consumes:

---
 rtl/ps2_key_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and scancode decoder; outputs are held-key levels for snake_ctlr.
// Pin-to-filtered-edge latency is 2+FILTER_LEN cycles; outputs update 1 cycle after the stop-bit fall; no backpressure.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk100Mhz,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       start,
    output logic       pause,
    output logic       resume,
    output logic       stop,
    output logic       u,
    output logic       d,
    output logic       l,
    output logic       r,
    output logic [7:0] scancode,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]    clkSync, dataSync;
    logic [FW-1:0] clkCnt, dataCnt;
    logic          clkFilt, dataFilt, clkFiltD;
    logic          fall;

    logic [1:0]    state;
    logic [2:0]    bitCnt;
    logic [7:0]    shreg;
    logic          parityBit;
    logic [TW-1:0] toCnt;
    logic          timeout, stopFall, byteOk, accept, reject;
    logic          brkFlag;

    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            clkSync  <= 2'b11;
            dataSync <= 2'b11;
        end else begin
            clkSync  <= {clkSync[0], ps2_clk};
            dataSync <= {dataSync[0], ps2_data};
        end
    end

    // A filtered line only follows its synchronised copy after FILTER_LEN consecutive disagreeing cycles
    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            clkFilt  <= 1'b1;
            dataFilt <= 1'b1;
            clkFiltD <= 1'b1;
            clkCnt   <= '0;
            dataCnt  <= '0;
        end else begin
            clkFiltD <= clkFilt;
            if (clkSync[1] == clkFilt) begin
                clkCnt <= '0;
            end else if (clkCnt == FW'(FILTER_LEN - 1)) begin
                clkFilt <= clkSync[1];
                clkCnt  <= '0;
            end else begin
                clkCnt <= clkCnt + FW'(1);
            end
            if (dataSync[1] == dataFilt) begin
                dataCnt <= '0;
            end else if (dataCnt == FW'(FILTER_LEN - 1)) begin
                dataFilt <= dataSync[1];
                dataCnt  <= '0;
            end else begin
                dataCnt <= dataCnt + FW'(1);
            end
        end
    end

    assign fall     = clkFiltD & ~clkFilt;
    assign timeout  = (state != IDLE) && (toCnt == TW'(TIMEOUT_CYCLES));
    assign stopFall = fall && (state == STOP);
    assign byteOk   = dataFilt && ((^shreg ^ parityBit) == 1'b1);
    assign accept   = stopFall && byteOk && !timeout;
    assign reject   = timeout || (stopFall && !byteOk) || (fall && (state == IDLE) && dataFilt);

    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bitCnt    <= '0;
            shreg     <= '0;
            parityBit <= 1'b0;
            toCnt     <= '0;
        end else begin
            if (fall || state == IDLE) begin
                toCnt <= '0;
            end else begin
                toCnt <= toCnt + TW'(1);
            end

            if (timeout) begin
                state <= IDLE;
            end else if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dataFilt) begin
                            state  <= DATA;
                            bitCnt <= '0;
                        end
                    end
                    DATA: begin
                        shreg  <= {dataFilt, shreg[7:1]};
                        bitCnt <= bitCnt + 3'd1;
                        if (bitCnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parityBit <= dataFilt;
                        state     <= STOP;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // E0 needs no state: extended and keypad codes map to the same outputs
    always_ff @(posedge clk100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            scancode   <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            brkFlag    <= 1'b0;
            start      <= 1'b0;
            pause      <= 1'b0;
            resume     <= 1'b0;
            stop       <= 1'b0;
            u          <= 1'b0;
            d          <= 1'b0;
            l          <= 1'b0;
            r          <= 1'b0;
        end else begin
            code_valid <= accept;
            frame_err  <= reject;
            if (reject) begin
                brkFlag <= 1'b0;
            end else if (accept) begin
                scancode <= shreg;
                if (shreg == 8'hF0) begin
                    brkFlag <= 1'b1;
                end else if (shreg != 8'hE0) begin
                    brkFlag <= 1'b0;
                    case (shreg)
                        8'h1B:   start  <= ~brkFlag;
                        8'h4D:   pause  <= ~brkFlag;
                        8'h2D:   resume <= ~brkFlag;
                        8'h76:   stop   <= ~brkFlag;
                        8'h75:   u      <= ~brkFlag;
                        8'h72:   d      <= ~brkFlag;
                        8'h6B:   l      <= ~brkFlag;
                        8'h74:   r      <= ~brkFlag;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
